// File: rtl/fetch_controller.sv
// fetch_controller: program counter and fetch sequencer for the filter core.
// Streams instruction words to decode with stall skid, branch redirect and halt detection.
module fetch_controller #(
    parameter logic [7:0]  START_ADDR = 8'd0,
    parameter logic [15:0] HALT_WORD  = 16'hffff,
    parameter logic [7:0]  LAST_ADDR  = 8'd255
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [7:0]  i_branch_target,
    output logic [31:0] o_mem_addr,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_inst,
    output logic        o_inst_valid,
    output logic [7:0]  o_pc,
    output logic        o_busy,
    output logic        o_halted,
    output logic [15:0] o_fetch_count,
    output logic [15:0] o_stall_count
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d, infl_pc_q, infl_pc_d, skid_pc_q, skid_pc_d, pc_q, pc_d;
    logic        req_q, req_d, infl_q, infl_d, skid_v_q, skid_v_d, valid_q, valid_d;
    logic [15:0] skid_q, skid_d, inst_q, inst_d, fcnt_q, fcnt_d, scnt_q, scnt_d;
    logic        hold, consume, src_v;
    logic [15:0] src_w;
    logic [7:0]  src_pc;
    assign hold    = valid_q & i_stall;
    assign consume = valid_q & ~i_stall;
    assign src_v   = skid_v_q | infl_q;
    assign src_w   = skid_v_q ? skid_q : i_mem_data;
    assign src_pc  = skid_v_q ? skid_pc_q : infl_pc_q;
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_d     = req_q;
        infl_d    = infl_q;
        infl_pc_d = infl_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        skid_v_d  = skid_v_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        fcnt_d    = fcnt_q;
        scnt_d    = scnt_q;
        if (state_q != FETCH) begin
            if (i_start) begin
                state_d  = FETCH;
                addr_d   = START_ADDR;
                req_d    = 1'b1;
                infl_d   = 1'b0;
                skid_v_d = 1'b0;
                valid_d  = 1'b0;
                fcnt_d   = '0;
                scnt_d   = '0;
            end
        end else begin
            fcnt_d = (consume && fcnt_q != 16'hffff) ? fcnt_q + 16'd1 : fcnt_q;
            scnt_d = (hold && scnt_q != 16'hffff) ? scnt_q + 16'd1 : scnt_q;
            if (i_branch_taken) begin
                addr_d   = i_branch_target;
                req_d    = 1'b1;
                infl_d   = 1'b0;
                skid_v_d = 1'b0;
                valid_d  = 1'b0;
            end else if ((consume && pc_q == LAST_ADDR) || (!hold && src_v && src_w == HALT_WORD)) begin
                state_d  = HALT;
                req_d    = 1'b0;
                infl_d   = 1'b0;
                skid_v_d = 1'b0;
                valid_d  = 1'b0;
            end else begin
                // a stalled request is dropped and re-presented, so only one word ever needs the skid
                infl_d    = req_q & ~hold;
                infl_pc_d = addr_q;
                if (req_q && !hold) begin
                    addr_d = (addr_q == LAST_ADDR) ? addr_q : addr_q + 8'd1;
                    req_d  = addr_q != LAST_ADDR;
                end
                if (hold) begin
                    if (infl_q) begin
                        skid_d    = i_mem_data;
                        skid_pc_d = infl_pc_q;
                        skid_v_d  = 1'b1;
                    end
                end else begin
                    valid_d  = src_v;
                    inst_d   = src_v ? src_w : inst_q;
                    pc_d     = src_v ? src_pc : pc_q;
                    skid_v_d = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            req_q     <= 1'b0;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
            skid_v_q  <= 1'b0;
            inst_q    <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            fcnt_q    <= '0;
            scnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            skid_v_q  <= skid_v_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            fcnt_q    <= fcnt_d;
            scnt_q    <= scnt_d;
        end
    end
    assign o_mem_addr    = {24'd0, addr_q};
    assign o_inst        = inst_q;
    assign o_inst_valid  = valid_q;
    assign o_pc          = pc_q;
    assign o_busy        = state_q == FETCH;
    assign o_halted      = state_q == HALT;
    assign o_fetch_count = fcnt_q;
    assign o_stall_count = scnt_q;
endmodule
